// File: rtl/structures.sv
// Shared types for the main-memory controller slice.
package structures;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND,
    RELEASE
  } mem_ctrl_state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous line RAM with a registered read port.
module ram_array #(
   parameter int    WIDTH     = 128,
   parameter int    DEPTH     = 1024,
   parameter string INIT_FILE = ""
) (
   input  logic                     clock,
   input  logic                     en,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] index,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // rdata only moves on reads, so a write leaves the last read line visible.
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) begin
            mem[index] <= wdata;
         end else begin
            rdata <= mem[index];
         end
      end
   end

endmodule

// File: rtl/main_memory_controller.sv
// Line-granular main-memory controller: fixed-latency single-request FSM in front of ram_array.
module main_memory_controller
  import structures::*;
#(
  parameter int    BUS_WIDTH_BYTES = 16,
  parameter int    ADDR_WIDTH      = 32,
  parameter int    DEPTH_LINES     = 1024,
  parameter int    LATENCY         = 4,
  parameter int    TAG_WIDTH       = 1,
  parameter string INIT_FILE       = ""
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         read,
  input  logic                         write,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [TAG_WIDTH-1:0]         tag_in,
  input  logic [BUS_WIDTH_BYTES*8-1:0] data_in,
  output logic [BUS_WIDTH_BYTES*8-1:0] data_out,
  output logic [TAG_WIDTH-1:0]         tag_out,
  output logic                         ready,
  output logic                         busy
);

  localparam int LINE_W   = BUS_WIDTH_BYTES * 8;
  localparam int OFFSET_W = $clog2(BUS_WIDTH_BYTES);
  localparam int INDEX_W  = $clog2(DEPTH_LINES);
  localparam int CNT_W    = $clog2(LATENCY) + 1;

  mem_ctrl_state_e      state_q;
  logic [CNT_W-1:0]     count_q;
  logic [INDEX_W-1:0]   index_q;
  logic [LINE_W-1:0]    wdata_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 isWrite_q;
  logic [TAG_WIDTH-1:0] tagOut_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 dataValid_q;
  logic                 ramEn;
  logic [LINE_W-1:0]    ramRdata;
  logic                 unusedAddr;

  // Offset and upper address bits are deliberately ignored, so addresses wrap.
  assign unusedAddr = ^address;

  // The RAM access fires on the WAIT->RESPOND edge; its registered read lands in RESPOND.
  assign ramEn = (state_q == WAIT) && (count_q == '0) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      index_q     <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      isWrite_q   <= 1'b0;
      tagOut_q    <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      dataValid_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (read || write) begin
            state_q   <= WAIT;
            busy_q    <= 1'b1;
            count_q   <= CNT_W'(LATENCY - 1);
            index_q   <= address[OFFSET_W +: INDEX_W];
            wdata_q   <= data_in;
            tag_q     <= tag_in;
            isWrite_q <= write;
          end
        end
        WAIT: begin
          if (count_q == '0) begin
            state_q  <= RESPOND;
            ready_q  <= 1'b1;
            tagOut_q <= tag_q;
            if (!isWrite_q) begin
              dataValid_q <= 1'b1;
            end
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        RESPOND: begin
          state_q <= RELEASE;
        end
        RELEASE: begin
          if (!read && !write) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  ram_array #(
    .WIDTH    (LINE_W),
    .DEPTH    (DEPTH_LINES),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clock(clock),
    .en   (ramEn),
    .we   (isWrite_q),
    .index(index_q),
    .wdata(wdata_q),
    .rdata(ramRdata)
  );

  // Until the first read after reset the RAM output register holds nothing meaningful.
  assign data_out = dataValid_q ? ramRdata : '0;
  assign tag_out  = tagOut_q;
  assign ready    = ready_q;
  assign busy     = busy_q;

endmodule
